// File: rtl/dp_cu_pkg.sv
// Shared types for the parametrised datapath/control-unit pair: FSM states,
// opcodes, and the control word the CU hands to the DP each cycle.
package dp_cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_EXEC  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic [1:0] {
    SRC_A   = 2'd0,
    SRC_B   = 2'd1,
    SRC_ALU = 2'd2
  } wr_src_t;

  typedef struct packed {
    logic       lat_en;
    logic       wr_en;
    logic [1:0] wr_addr;
    wr_src_t    wr_src;
    logic [1:0] rd_a;
    logic [1:0] rd_b;
    logic [2:0] alu_op;
    logic       flag_en;
    logic       out_ld;
  } ctrl_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: arithmetic modulo 2^WIDTH, carry is bit WIDTH of the
// add/accumulate or the borrow of a subtract.
module dp_alu
  import dp_cu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             cy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] WLIM = (WIDTH+1)'(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] acc_sum;
  logic           shift_oob;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign acc_sum   = {1'b0, acc} + {1'b0, a};
  // Shift amounts of WIDTH or more flush the operand entirely.
  assign shift_oob = ({1'b0, b} >= WLIM);

  always_comb begin
    y  = '0;
    cy = 1'b0;
    case (op)
      OP_ADD: {cy, y} = sum;
      OP_SUB: {cy, y} = diff;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: y = shift_oob ? '0 : (a << b[SHW-1:0]);
      OP_SHR: y = shift_oob ? '0 : (a >> b[SHW-1:0]);
      OP_ACC: {cy, y} = acc_sum;
      default: ;
    endcase
  end

endmodule

// File: rtl/dp_cu_param.sv
// FSM-sequenced datapath: latch operands on go, load R1/R2, run one ALU op
// into R3, then present R3 and its flags with a one-cycle done pulse.
module dp_cu_param
  import dp_cu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [2:0]       cs,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  state_t           state;
  ctrl_t            ctrl;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] r1, r2, r3;
  logic [WIDTH-1:0] rd_a_val, rd_b_val, wr_data, alu_y;
  logic             alu_cy, carry_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          state <= S_LOAD1;
          busy  <= 1'b1;
        end
        S_LOAD1: state <= S_LOAD2;
        S_LOAD2: state <= S_EXEC;
        S_EXEC:  state <= S_OUT;
        S_OUT: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign cs = state;

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = op_q;
    case (state)
      S_IDLE:  ctrl.lat_en = 1'b1;
      S_LOAD1: begin
        ctrl.wr_en   = 1'b1;
        ctrl.wr_addr = 2'd1;
        ctrl.wr_src  = SRC_A;
      end
      S_LOAD2: begin
        ctrl.wr_en   = 1'b1;
        ctrl.wr_addr = 2'd2;
        ctrl.wr_src  = SRC_B;
      end
      S_EXEC: begin
        ctrl.wr_en   = 1'b1;
        ctrl.wr_addr = 2'd3;
        ctrl.wr_src  = SRC_ALU;
        ctrl.rd_a    = 2'd1;
        ctrl.rd_b    = 2'd2;
        ctrl.flag_en = 1'b1;
      end
      S_OUT:   ctrl.out_ld = 1'b1;
      default: ;
    endcase
  end

  // R0 has no storage; address 0 reads as zero on both ports.
  always_comb begin
    case (ctrl.rd_a)
      2'd1:    rd_a_val = r1;
      2'd2:    rd_a_val = r2;
      2'd3:    rd_a_val = r3;
      default: rd_a_val = '0;
    endcase
    case (ctrl.rd_b)
      2'd1:    rd_b_val = r1;
      2'd2:    rd_b_val = r2;
      2'd3:    rd_b_val = r3;
      default: rd_b_val = '0;
    endcase
  end

  always_comb begin
    case (ctrl.wr_src)
      SRC_A:   wr_data = a_q;
      SRC_B:   wr_data = b_q;
      SRC_ALU: wr_data = alu_y;
      default: wr_data = '0;
    endcase
  end

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (rd_a_val),
    .b   (rd_b_val),
    .acc (r3),
    .op  (ctrl.alu_op),
    .y   (alu_y),
    .cy  (alu_cy)
  );

  // R3 is only cleared by reset, which is what lets ACC accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      out     <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      if (ctrl.lat_en && go) begin
        op_q <= op;
        a_q  <= in1;
        b_q  <= in2;
      end
      if (ctrl.wr_en) begin
        case (ctrl.wr_addr)
          2'd1:    r1 <= wr_data;
          2'd2:    r2 <= wr_data;
          2'd3:    r3 <= wr_data;
          default: ;
        endcase
      end
      if (ctrl.flag_en) begin
        carry_q <= alu_cy;
        zero_q  <= (alu_y == '0);
      end
      if (ctrl.out_ld) begin
        out   <= r3;
        carry <= carry_q;
        zero  <= zero_q;
      end
    end
  end

endmodule

// File: tb/tb_dp_cu_param.sv
// Self-checking bench for dp_cu_param (WIDTH=4): a latency/arithmetic model
// checked every cycle, plus directed vectors with literal expectations.
module tb_dp_cu_param;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [2:0]   cs;
  logic         busy, done, carry, zero;
  logic [W-1:0] out;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  int m_out = 0;
  int m_cy = 0;
  int m_z = 0;
  int m_acc = 0;
  int p_res = 0;
  int p_cy = 0;

  dp_cu_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .cs    (cs),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .carry (carry),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  function automatic void model_alu(input int o, input int a, input int b,
                                    input int acc, output int r, output int c);
    int s;
    r = 0;
    c = 0;
    case (o)
      0: begin s = a + b; r = s % M; c = (s >= M) ? 1 : 0; end
      1: begin r = (a - b + M) % M; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= W) ? 0 : ((a * (1 << b)) % M);
      6: r = (b >= W) ? 0 : (a / (1 << b));
      default: begin s = acc + a; r = s % M; c = (s >= M) ? 1 : 0; end
    endcase
  endfunction

  // Model: m_cnt counts edges since an accepted go; result lands at edge 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_out = 0; m_cy = 0; m_z = 0; m_acc = 0;
    end else if (m_cnt == 0) begin
      if (go) begin
        model_alu(int'(op), int'(in1), int'(in2), m_acc, p_res, p_cy);
        m_acc = p_res;
        m_cnt = 1;
      end
    end else begin
      if (m_cnt == 4) begin
        m_out = p_res; m_cy = p_cy; m_z = (p_res == 0) ? 1 : 0;
      end
      m_cnt = (m_cnt == 5) ? 0 : m_cnt + 1;
    end
  end

  task automatic cmp(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual=%0d expected=%0d", name, $time, actual, expected);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp("cmp_cs",    int'(cs),    m_cnt);
      cmp("cmp_busy",  int'(busy),  (m_cnt != 0) ? 1 : 0);
      cmp("cmp_done",  int'(done),  (m_cnt == 5) ? 1 : 0);
      cmp("cmp_out",   int'(out),   m_out);
      cmp("cmp_carry", int'(carry), m_cy);
      cmp("cmp_zero",  int'(zero),  m_z);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    cmp(name, actual, expected);
  endtask

  // Launch one op at a negedge and return at the negedge where done is high.
  task automatic applyStimulus(input logic [2:0] o, input int a, input int b);
    int n;
    @(negedge clk);
    op = o; in1 = W'(a); in2 = W'(b); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      go = 1'($urandom); in1 = W'($urandom); in2 = W'($urandom); op = 3'($urandom);
    end
    checkOutput("rst_out", int'(out), 0);
    checkOutput("rst_carry", int'(carry), 0);
    checkOutput("rst_zero", int'(zero), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cs", int'(cs), 0);
    go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_cs", int'(cs), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int dones;
    doReset();

    applyStimulus(OPC(0), 9, 8);
    checkOutput("add_cs", int'(cs), 5);
    checkOutput("add_out", int'(out), 1);
    checkOutput("add_carry", int'(carry), 1);
    checkOutput("add_zero", int'(zero), 0);
    @(negedge clk);
    checkOutput("add_done_once", int'(done), 0);
    checkOutput("add_busy_end", int'(busy), 0);

    applyStimulus(OPC(1), 3, 5);
    checkOutput("sub_out", int'(out), 14);
    checkOutput("sub_borrow", int'(carry), 1);
    applyStimulus(OPC(1), 5, 5);
    checkOutput("sub0_out", int'(out), 0);
    checkOutput("sub0_zero", int'(zero), 1);
    checkOutput("sub0_carry", int'(carry), 0);

    applyStimulus(OPC(2), 12, 10);
    checkOutput("and_out", int'(out), 8);
    applyStimulus(OPC(4), 12, 10);
    checkOutput("xor_out", int'(out), 6);

    doReset();
    applyStimulus(OPC(7), 6, 0);
    checkOutput("acc1_out", int'(out), 6);
    checkOutput("acc1_carry", int'(carry), 0);
    applyStimulus(OPC(7), 6, 0);
    checkOutput("acc2_out", int'(out), 12);
    checkOutput("acc2_carry", int'(carry), 0);
    applyStimulus(OPC(7), 6, 0);
    checkOutput("acc3_out", int'(out), 2);
    checkOutput("acc3_carry", int'(carry), 1);

    applyStimulus(OPC(5), 3, 2);
    checkOutput("shl_out", int'(out), 12);
    applyStimulus(OPC(5), 3, 5);
    checkOutput("shl_oob_out", int'(out), 0);
    checkOutput("shl_oob_zero", int'(zero), 1);
    applyStimulus(OPC(6), 12, 2);
    checkOutput("shr_out", int'(out), 3);

    // go re-pulsed with new operands while the FSM is busy.
    @(negedge clk);
    op = 3'b000; in1 = 4'd9; in2 = 4'd8; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    checkOutput("busy_cs", int'(cs), 2);
    go = 1'b1; in1 = 4'd15;
    @(negedge clk);
    go = 1'b0;
    dones = 0;
    while (!done && dones < 10) begin
      @(negedge clk);
      dones++;
    end
    checkOutput("ignore_go_out", int'(out), 1);
    checkOutput("ignore_go_carry", int'(carry), 1);

    // Asynchronous reset in the middle of EXEC, with R3 holding 6.
    doReset();
    applyStimulus(OPC(7), 6, 0);
    checkOutput("pre_acc_out", int'(out), 6);
    @(negedge clk);
    op = 3'b111; in1 = 4'd6; in2 = 4'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("exec_cs", int'(cs), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_cs", int'(cs), 0);
    checkOutput("async_out", int'(out), 0);
    checkOutput("async_busy", int'(busy), 0);
    #4 rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("async_no_done", dones, 0);
    applyStimulus(OPC(7), 6, 0);
    checkOutput("post_rst_acc", int'(out), 6);
    checkOutput("post_rst_carry", int'(carry), 0);

    // go held high: exactly one IDLE cycle between back-to-back ops.
    @(negedge clk);
    op = 3'b011; in1 = 4'd5; in2 = 4'd10; go = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("held_done", int'(done), 1);
    checkOutput("held_or_out", int'(out), 15);
    @(negedge clk);
    checkOutput("held_idle", int'(cs), 0);
    @(negedge clk);
    checkOutput("held_restart", int'(cs), 1);
    go = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [2:0] OPC(input int v);
    return 3'(v);
  endfunction

endmodule
